// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile bundle plus the decode-side read ports and status outputs.
// Latency: none, this is wiring only.
// Backpressure: none; the pipeline advances every clock.
interface wb_regfile_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              memtoreg_reg;
    logic              reg_write_reg;
    logic [DATA_W-1:0] read_data_reg;
    logic [DATA_W-1:0] alu_out_reg;
    logic [ADDR_W-1:0] instr_rd_reg;
    logic              halt_reg;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic              halted;
    logic [15:0]       wb_count;

    // Pipeline and decode side: drives MEM/WB values and read addresses.
    modport master (
        output memtoreg_reg, reg_write_reg, read_data_reg, alu_out_reg,
               instr_rd_reg, halt_reg, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, halted, wb_count
    );

    // Register file side.
    modport slave (
        input  memtoreg_reg, reg_write_reg, read_data_reg, alu_out_reg,
               instr_rd_reg, halt_reg, rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, halted, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select + 8x16 register file (r0 = 0), sticky halt, commit counter; WB_BYPASS_EN adds write-through reads.
// Latency: writes land on the clock edge; reads and wb_data are combinational (0 cycles).
// Backpressure: none; a commit is accepted every cycle until halted, after which writes are dropped.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic              r_halted;
    logic [15:0]       r_wb_count;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_commit;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    // Write-back select is always live; forwarding logic depends on it even when no write happens.
    always_comb begin
        w_wb_data = bus.memtoreg_reg ? bus.read_data_reg : bus.alu_out_reg;
        w_commit  = bus.reg_write_reg && !r_halted && (bus.instr_rd_reg != '0);
    end

    // Read port helper: r0 is constant zero; optional same-cycle write-through of the committing value.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        if (addr != '0) begin
            v = r_regs[addr];
`ifdef WB_BYPASS_EN
            if (w_commit && (addr == bus.instr_rd_reg)) begin
                v = w_wb_data;
            end
`endif
        end
        return v;
    endfunction

    // Two independent combinational read ports for decode.
    always_comb begin
        w_rs_data = read_port(bus.rs_addr);
        w_rt_data = read_port(bus.rt_addr);
    end

    // Register array: commit the write-back value; r0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[bus.instr_rd_reg] <= w_wb_data;
        end
    end

    // Sticky halt: the halting cycle's own write still commits because w_commit samples the old flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (bus.halt_reg) begin
            r_halted <= 1'b1;
        end
    end

    // Commit counter, wraps silently at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_wb_count <= r_wb_count + 16'd1;
        end
    end

    assign bus.wb_data  = w_wb_data;
    assign bus.rs_data  = w_rs_data;
    assign bus.rt_data  = w_rt_data;
    assign bus.halted   = r_halted;
    assign bus.wb_count = r_wb_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus randomized traffic against an array-based reference model.
// Latency: checks comb outputs mid-cycle and committed state 1 time unit after each rising edge.
// Backpressure: not applicable; the bench applies one MEM/WB vector per clock.
module tb_wb_regfile;
    logic clk;
    logic reset;

    wb_regfile_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    wb_regfile #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain array of register contents, commit count, halt flag.
    logic [15:0] model [8];
    logic [15:0] ref_count;
    logic        ref_halted;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_wb();
        return bus.memtoreg_reg ? bus.read_data_reg : bus.alu_out_reg;
    endfunction

    function automatic bit ref_commit();
        return bus.reg_write_reg && !ref_halted && (bus.instr_rd_reg != 3'd0);
    endfunction

    // Expected read value for the inputs currently applied and the model state.
    function automatic logic [15:0] ref_read(input logic [2:0] addr);
        if (addr == 3'd0) return 16'h0000;
`ifdef WB_BYPASS_EN
        if (ref_commit() && addr == bus.instr_rd_reg) return ref_wb();
`endif
        return model[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        ref_count  = 16'h0000;
        ref_halted = 1'b0;
    endtask

    // Apply the effect of one rising edge with the currently driven inputs.
    task automatic model_edge();
        if (ref_commit()) begin
            model[bus.instr_rd_reg] = ref_wb();
            ref_count = ref_count + 16'd1;
        end
        if (bus.halt_reg) ref_halted = 1'b1;
    endtask

    task automatic drive(input logic m2r, input logic rw, input logic [15:0] rdat,
                         input logic [15:0] alu, input logic [2:0] rd, input logic hlt,
                         input logic [2:0] rs, input logic [2:0] rt);
        bus.memtoreg_reg  = m2r;
        bus.reg_write_reg = rw;
        bus.read_data_reg = rdat;
        bus.alu_out_reg   = alu;
        bus.instr_rd_reg  = rd;
        bus.halt_reg      = hlt;
        bus.rs_addr       = rs;
        bus.rt_addr       = rt;
    endtask

    // One clock with inputs already driven: check comb outputs mid-cycle, then state after the edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        check({tag, ".wb_data"}, bus.wb_data, ref_wb());
        check({tag, ".rs_pre"},  bus.rs_data, ref_read(bus.rs_addr));
        check({tag, ".rt_pre"},  bus.rt_data, ref_read(bus.rt_addr));
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".rs_post"}, bus.rs_data, ref_read(bus.rs_addr));
        check({tag, ".rt_post"}, bus.rt_data, ref_read(bus.rt_addr));
        check({tag, ".halted"},  16'(bus.halted), 16'(ref_halted));
        check({tag, ".count"},   bus.wb_count, ref_count);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd0, 3'd0);

        // Reset and sweep all addresses on both ports.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.rs_addr = 3'(a);
            bus.rt_addr = 3'(7 - a);
            #1;
            check("rst.rs", bus.rs_data, 16'h0000);
            check("rst.rt", bus.rt_data, 16'h0000);
        end
        check("rst.halted", 16'(bus.halted), 16'h0000);
        check("rst.count", bus.wb_count, 16'h0000);

        // ALU write to r3, then load write to r5.
        drive(1'b0, 1'b1, 16'hDEAD, 16'h1234, 3'd3, 1'b0, 3'd3, 3'd5);
        cycle("wr_r3");
        drive(1'b1, 1'b1, 16'hBEEF, 16'h5555, 3'd5, 1'b0, 3'd3, 3'd5);
        cycle("wr_r5");
        check("dir.r3", bus.rs_data, 16'h1234);
        check("dir.r5", bus.rt_data, 16'hBEEF);
        check("dir.count", bus.wb_count, 16'd2);

        // Write to r0 is discarded and not counted.
        drive(1'b0, 1'b1, 16'h0, 16'hFFFF, 3'd0, 1'b0, 3'd0, 3'd0);
        cycle("wr_r0");
        check("r0.read", bus.rs_data, 16'h0000);
        check("r0.count", bus.wb_count, 16'd2);

        // Same-cycle read of the register being written.
        drive(1'b0, 1'b1, 16'h0, 16'h0001, 3'd4, 1'b0, 3'd4, 3'd4);
        cycle("pre_r4");
        drive(1'b0, 1'b1, 16'h0, 16'h00A5, 3'd4, 1'b0, 3'd4, 3'd3);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("byp.before", bus.rs_data, 16'h00A5);
`else
        check("byp.before", bus.rs_data, 16'h0001);
`endif
        @(posedge clk);
        model_edge();
        #1;
        check("byp.after", bus.rs_data, 16'h00A5);

        // Randomized traffic, no halt.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  3'($urandom), 1'b0, 3'($urandom), 3'($urandom));
            cycle("rand");
        end

        // Halt together with a write: write commits, then everything is frozen.
        drive(1'b0, 1'b1, 16'h0, 16'h0777, 3'd2, 1'b1, 3'd2, 3'd2);
        cycle("halt_wr");
        check("halt.r2", bus.rs_data, 16'h0777);
        check("halt.flag", 16'(bus.halted), 16'h0001);
        drive(1'b0, 1'b1, 16'h0, 16'h1111, 3'd2, 1'b0, 3'd2, 3'd1);
        cycle("post_halt");
        check("frozen.r2", bus.rs_data, 16'h0777);
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom), 1'b1, 16'($urandom), 16'($urandom),
                  3'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
            cycle("halted_rand");
        end

        // Asynchronous reset between edges takes effect without a clock.
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd2, 3'd2);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("areset.halted", 16'(bus.halted), 16'h0000);
        check("areset.r2", bus.rs_data, 16'h0000);
        check("areset.count", bus.wb_count, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Counter wrap: 65535 commits reach 0xFFFF, the next one wraps to zero.
        drive(1'b0, 1'b1, 16'h0, 16'h0042, 3'd1, 1'b0, 3'd1, 3'd0);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        check("wrap.ffff", bus.wb_count, 16'hFFFF);
        cycle("wrap_edge");
        check("wrap.zero", bus.wb_count, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
